sm83_regfile_mp: RTL and testbench

// - Parametrised multi-port 16-bit register-pair file for the SM83 core.
// - Adds three write sources: an 8-bit byte port, a 16-bit port and an increment/decrement unit (IDU) for HL+/HL-/SP/PC.
// - Adds NUM_RPORTS combinational read ports and a handshaked debug stream that dumps a coherent snapshot of all pairs.
// - Sits between the decode/sequencer and the ALU/bus unit.

---
 rtl/sm83_regfile_mp.sv | 169 ++++++++++++++++
 tb/tb_sm83_regfile_mp.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sm83_regfile_mp.sv
// rtl/sm83_regfile_mp.sv - SM83 multi-port register-pair file with IDU and debug snapshot stream (optional SM83_RF_BYPASS_EN read forwarding)
module sm83_regfile_mp #(
  parameter int NUM_PAIRS  = 6,
  parameter int NUM_RPORTS = 2,
  localparam int IDX_W     = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        w0_en,
  input  logic [IDX_W-1:0]            w0_idx,
  input  logic                        w0_hi,
  input  logic [7:0]                  w0_data,
  input  logic                        w1_en,
  input  logic [IDX_W-1:0]            w1_idx,
  input  logic [15:0]                 w1_data,
  input  logic                        idu_req,
  input  logic [IDX_W-1:0]            idu_idx,
  input  logic                        idu_dec,
  output logic [15:0]                 idu_q,
  output logic                        idu_valid,
  input  logic [NUM_RPORTS*IDX_W-1:0] rd_idx,
  output logic [NUM_RPORTS*16-1:0]    rd_data,
  input  logic                        dbg_start,
  output logic                        dbg_busy,
  output logic                        dbg_valid,
  input  logic                        dbg_ready,
  output logic [IDX_W-1:0]            dbg_idx,
  output logic [15:0]                 dbg_data,
  output logic                        dbg_last
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PAIRS - 1);

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  logic [15:0]      pairs [NUM_PAIRS];
  logic [15:0]      nxt   [NUM_PAIRS];
  logic [15:0]      snap  [NUM_PAIRS];
  logic [15:0]      idu_cur;
  logic [15:0]      idu_res;
  logic             idu_in_range;
  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx_nxt;
  logic             snap_load;

  // IDU operand select and 16-bit modulo inc/dec; out-of-range target yields 0
  always_comb begin
    idu_cur      = '0;
    idu_in_range = 1'b0;
    for (int i = 0; i < NUM_PAIRS; i++) begin
      if (idu_idx == IDX_W'(i)) begin
        idu_cur      = pairs[i];
        idu_in_range = 1'b1;
      end
    end
    idu_res = idu_in_range ? (idu_dec ? idu_cur - 16'd1 : idu_cur + 16'd1) : 16'h0000;
  end

  // Post-edge value per pair; later assignments win, giving W0 > W1 > IDU per byte
  always_comb begin
    for (int i = 0; i < NUM_PAIRS; i++) begin
      nxt[i] = pairs[i];
      if (idu_req && idu_idx == IDX_W'(i)) nxt[i] = idu_res;
      if (w1_en && w1_idx == IDX_W'(i)) nxt[i] = w1_data;
      if (w0_en && w0_idx == IDX_W'(i)) begin
        if (w0_hi) nxt[i][15:8] = w0_data;
        else       nxt[i][7:0]  = w0_data;
      end
    end
  end

  // Pair storage
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_PAIRS; i++) pairs[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_PAIRS; i++) pairs[i] <= nxt[i];
    end
  end

  // IDU result register; reported even when a higher-priority write overrides the pair
  always_ff @(posedge clk) begin
    if (rst) begin
      idu_q     <= '0;
      idu_valid <= 1'b0;
    end else begin
      idu_valid <= idu_req;
      if (idu_req) idu_q <= idu_res;
    end
  end

  // Independent read ports; unmatched indices read as 0
  always_comb begin
    rd_data = '0;
    for (int p = 0; p < NUM_RPORTS; p++) begin
      for (int i = 0; i < NUM_PAIRS; i++) begin
        if (rd_idx[p*IDX_W +: IDX_W] == IDX_W'(i)) begin
`ifdef SM83_RF_BYPASS_EN
          rd_data[p*16 +: 16] = nxt[i];
`else
          rd_data[p*16 +: 16] = pairs[i];
`endif
        end
      end
    end
  end

  // Dump FSM next-state and handshake outputs
  always_comb begin
    state_nxt = state;
    idx_nxt   = dbg_idx;
    snap_load = 1'b0;
    dbg_busy  = 1'b0;
    dbg_valid = 1'b0;
    dbg_last  = 1'b0;
    case (state)
      S_IDLE: begin
        if (dbg_start) begin
          snap_load = 1'b1;
          idx_nxt   = '0;
          state_nxt = S_STREAM;
        end
      end
      S_STREAM: begin
        dbg_busy  = 1'b1;
        dbg_valid = 1'b1;
        dbg_last  = (dbg_idx == LAST_IDX);
        if (dbg_ready) begin
          if (dbg_idx == LAST_IDX) begin
            state_nxt = S_IDLE;
            idx_nxt   = '0;
          end else begin
            idx_nxt = dbg_idx + IDX_W'(1);
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Dump FSM state and beat index registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      dbg_idx <= '0;
    end else begin
      state   <= state_nxt;
      dbg_idx <= idx_nxt;
    end
  end

  // Snapshot captures pre-edge pair values, so start-cycle writes are excluded
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_PAIRS; i++) snap[i] <= '0;
    end else if (snap_load) begin
      for (int i = 0; i < NUM_PAIRS; i++) snap[i] <= pairs[i];
    end
  end

  // Beat data mux from the frozen snapshot
  always_comb begin
    dbg_data = '0;
    for (int i = 0; i < NUM_PAIRS; i++) begin
      if (dbg_idx == IDX_W'(i)) dbg_data = snap[i];
    end
  end

endmodule

// File: tb/tb_sm83_regfile_mp.sv
// tb/tb_sm83_regfile_mp.sv - scoreboard bench for sm83_regfile_mp
module tb_sm83_regfile_mp;

  typedef struct packed {
    logic [2:0]  idx;
    logic [15:0] data;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        w0_en, w0_hi, w1_en, idu_req, idu_dec;
  logic [2:0]  w0_idx, w1_idx, idu_idx;
  logic [7:0]  w0_data;
  logic [15:0] w1_data;
  logic [15:0] idu_q;
  logic        idu_valid;
  logic [5:0]  rd_idx;
  logic [31:0] rd_data;
  logic        dbg_start, dbg_busy, dbg_valid, dbg_ready, dbg_last;
  logic [2:0]  dbg_idx;
  logic [15:0] dbg_data;

  logic        rd_chk = 1'b0;
  logic        st_chk = 1'b0;
  logic [31:0] rd_exp  [$];
  logic [3:0]  st_exp  [$];
  logic [15:0] idu_exp [$];
  beat_t       dbg_exp [$];

  int n_cmp = 0;
  int n_bad = 0;

  sm83_regfile_mp #(.NUM_PAIRS(6), .NUM_RPORTS(2)) dut (
    .clk(clk), .rst(rst),
    .w0_en(w0_en), .w0_idx(w0_idx), .w0_hi(w0_hi), .w0_data(w0_data),
    .w1_en(w1_en), .w1_idx(w1_idx), .w1_data(w1_data),
    .idu_req(idu_req), .idu_idx(idu_idx), .idu_dec(idu_dec),
    .idu_q(idu_q), .idu_valid(idu_valid),
    .rd_idx(rd_idx), .rd_data(rd_data),
    .dbg_start(dbg_start), .dbg_busy(dbg_busy), .dbg_valid(dbg_valid),
    .dbg_ready(dbg_ready), .dbg_idx(dbg_idx), .dbg_data(dbg_data),
    .dbg_last(dbg_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic unexpected(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: output with no expectation queued", nm);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares whatever the DUT presents against the queued expectations
  always @(negedge clk) begin
    logic [31:0] e;
    logic [3:0]  s;
    logic [15:0] q;
    beat_t       b;
    if (rd_chk) begin
      if (rd_exp.size() == 0) unexpected("rd");
      else begin
        e = rd_exp.pop_front();
        chk("rd_port0", {16'h0, rd_data[15:0]}, {16'h0, e[15:0]});
        chk("rd_port1", {16'h0, rd_data[31:16]}, {16'h0, e[31:16]});
      end
    end
    if (st_chk) begin
      if (st_exp.size() == 0) unexpected("status");
      else begin
        s = st_exp.pop_front();
        chk("status_busy_valid_last_iduv", {28'h0, dbg_busy, dbg_valid, dbg_last, idu_valid}, {28'h0, s});
      end
    end
    if (idu_valid) begin
      if (idu_exp.size() == 0) unexpected("idu");
      else begin
        q = idu_exp.pop_front();
        chk("idu_q", {16'h0, idu_q}, {16'h0, q});
      end
    end
    if (dbg_valid && dbg_ready) begin
      if (dbg_exp.size() == 0) unexpected("dbg_beat");
      else begin
        b = dbg_exp.pop_front();
        chk("dbg_beat", {12'h0, dbg_idx, dbg_data, dbg_last}, {12'h0, b});
      end
    end else if (dbg_valid && dbg_exp.size() != 0) begin
      b = dbg_exp[0];
      chk("dbg_hold", {12'h0, dbg_idx, dbg_data, dbg_last}, {12'h0, b});
    end
  end

  initial begin
    logic [15:0] v;
    int          budget;
    rst = 1'b1;
    w0_en = 0; w0_idx = 0; w0_hi = 0; w0_data = 0;
    w1_en = 0; w1_idx = 0; w1_data = 0;
    idu_req = 0; idu_idx = 0; idu_dec = 0;
    rd_idx = 0; dbg_start = 0; dbg_ready = 0;
    tick(); tick();
    rst = 1'b0;

    // Reset state: every index on both ports reads 0, handshakes idle
    st_chk = 1'b1; st_exp.push_back(4'b0000);
    rd_chk = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rd_idx = {3'(7 - i), 3'(i)};
      rd_exp.push_back(32'h0);
      tick();
      st_chk = 1'b0;
    end
    rd_chk = 1'b0;

    // W0 hi beats W1 on idx2
    w1_en = 1; w1_idx = 2; w1_data = 16'h1234;
    w0_en = 1; w0_idx = 2; w0_hi = 1; w0_data = 8'hAA;
    rd_idx = {3'd2, 3'd2};
`ifdef SM83_RF_BYPASS_EN
    rd_chk = 1'b1; rd_exp.push_back({16'hAA34, 16'hAA34});
`endif
    tick();
    rd_chk = 1'b0;
    // W0 lo beats W1 on idx1
    w1_idx = 1; w1_data = 16'h5678;
    w0_idx = 1; w0_hi = 0; w0_data = 8'h11;
    rd_chk = 1'b1; rd_exp.push_back({16'hAA34, 16'hAA34});
    tick();
    rd_chk = 1'b0;
    w0_en = 0;
    // W1 beats IDU on idx3; idu_q still reports old+1
    w1_idx = 3; w1_data = 16'hCAFE;
    idu_req = 1; idu_idx = 3; idu_dec = 0; idu_exp.push_back(16'h0001);
    tick();
    w1_en = 0; idu_req = 0;
    rd_idx = {3'd3, 3'd1};
    rd_chk = 1'b1; rd_exp.push_back({16'hCAFE, 16'h5611});
    tick();
    rd_chk = 1'b0;

    // IDU wrap on idx4
    w1_en = 1; w1_idx = 4; w1_data = 16'hFFFF;
    tick();
    w1_en = 0;
    idu_req = 1; idu_idx = 4; idu_dec = 0; idu_exp.push_back(16'h0000);
    tick();
    idu_req = 0;
    rd_idx = {3'd4, 3'd4};
    rd_chk = 1'b1; rd_exp.push_back({16'h0000, 16'h0000});
    st_chk = 1'b1; st_exp.push_back(4'b0001);
    tick();
    rd_chk = 1'b0; st_chk = 1'b0;
    idu_req = 1; idu_dec = 1; idu_exp.push_back(16'hFFFF);
    tick();
    idu_req = 0;
    rd_chk = 1'b1; rd_exp.push_back({16'hFFFF, 16'hFFFF});
    tick();
    rd_chk = 1'b0;
    // Out-of-range IDU still pulses with 0
    idu_req = 1; idu_idx = 7; idu_dec = 0; idu_exp.push_back(16'h0000);
    tick();
    idu_req = 0;

    // Out-of-range writes are dropped
    w1_en = 1; w1_idx = 7; w1_data = 16'h7777;
    w0_en = 1; w0_idx = 6; w0_hi = 1; w0_data = 8'h66;
    tick();
    w1_en = 0; w0_en = 0;
    rd_chk = 1'b1;
    for (int i = 0; i < 6; i++) begin
      case (i)
        1: v = 16'h5611;
        2: v = 16'hAA34;
        3: v = 16'hCAFE;
        4: v = 16'hFFFF;
        default: v = 16'h0000;
      endcase
      rd_idx = {3'(6 + (i & 1)), 3'(i)};
      rd_exp.push_back({16'h0000, v});
      tick();
    end
    rd_chk = 1'b0;

    // Load 0x1000+i, then dump with a write to idx0 during STREAM
    w1_en = 1;
    for (int i = 0; i < 6; i++) begin
      w1_idx = 3'(i); w1_data = 16'h1000 + 16'(i);
      tick();
    end
    w1_en = 0;
    for (int i = 0; i < 6; i++)
      dbg_exp.push_back('{idx: 3'(i), data: 16'h1000 + 16'(i), last: (i == 5)});
    dbg_ready = 1; dbg_start = 1;
    tick();
    dbg_start = 0;
    w1_en = 1; w1_idx = 0; w1_data = 16'hBEEF;
    tick();
    w1_en = 0;
    tick(); tick();
    // idx3 now presented: stall 3 cycles with an ignored start pulse
    dbg_ready = 0;
    tick();
    dbg_start = 1;
    tick();
    dbg_start = 0;
    tick();
    dbg_ready = 1;
    budget = 0;
    while (dbg_busy && budget < 40) begin
      tick();
      budget++;
    end
    chk("dump_done_in_budget", {31'h0, dbg_busy}, 32'h0);
    chk("dump_beats_left", dbg_exp.size(), 32'h0);
    st_chk = 1'b1; st_exp.push_back(4'b0000);
    rd_idx = {3'd5, 3'd0};
    rd_chk = 1'b1; rd_exp.push_back({16'h1005, 16'hBEEF});
    tick();
    st_chk = 1'b0; rd_chk = 1'b0;

    // Reset mid-dump aborts it
    dbg_ready = 0; dbg_start = 1;
    tick();
    dbg_start = 0;
    st_chk = 1'b1; st_exp.push_back(4'b1100);
    tick();
    st_chk = 1'b0;
    rst = 1;
    tick();
    rst = 0;
    st_chk = 1'b1; st_exp.push_back(4'b0000);
    rd_chk = 1'b1; rd_exp.push_back({16'h0000, 16'h0000});
    tick();
    st_chk = 1'b0; rd_chk = 1'b0;
    dbg_ready = 1;
    tick(); tick(); tick();

    chk("idu_left", idu_exp.size(), 32'h0);
    chk("rd_left", rd_exp.size(), 32'h0);
    chk("st_left", st_exp.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
